// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1-to-4 stream demultiplexer.
// Holds the channel count, the channel-select type and default widths.
package demux_pkg;

    localparam int NUM_CH        = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_SEL_BITS  = 2;
    localparam int DEF_CNT_WIDTH = 8;

    typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: 1-entry valid/ready holding register plus saturating beat counter.
// Latency: load appears on out_valid/out_data one cycle after the load strobe.
// Backpressure: slot_ready = ~out_valid | out_ready, so a full slot accepts only when draining.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 out_ready,
    input  logic                 cnt_clr,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] beat_cnt,
    output logic                 slot_ready
);

    logic drain;

    assign drain      = out_valid & out_ready;
    assign slot_ready = ~out_valid | out_ready;

    // A load in the same cycle as a drain replaces the leaving beat and keeps out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a handshake in the same cycle; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (cnt_clr) begin
            beat_cnt <= '0;
        end else if (drain && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/demux_stream_1x4.sv
// Registered 1-to-4 stream demux: steers each input beat to the channel named by in_sel.
// Latency: 1 cycle from input handshake to out_valid; no combinational data path.
// Backpressure: in_ready reflects only the addressed slot, so a stalled channel blocks only its own beats.
module demux_stream_1x4
    import demux_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEL_BITS  = DEF_SEL_BITS,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [SEL_BITS-1:0]            in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_CH-1:0][WIDTH-1:0]     out_data,
    output logic [NUM_CH-1:0]              out_valid,
    input  logic [NUM_CH-1:0]              out_ready,
    input  logic                           cnt_clr,
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0] beat_cnt
);

    logic [NUM_CH-1:0] slot_ready;
    logic [NUM_CH-1:0] load;
    logic              in_hs;
    ch_sel_t           sel;

    assign sel      = ch_sel_t'(in_sel);
    assign in_ready = slot_ready[sel];
    // Gating with in_valid first keeps an unknown select from disturbing any slot when idle.
    assign in_hs    = in_valid & in_ready & ~rst;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        localparam ch_sel_t CH_ID = ch_sel_t'(i);

        assign load[i] = in_hs & (sel == CH_ID);

        demux_slot #(
            .WIDTH     (WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[i]),
            .load_data  (in_data),
            .out_ready  (out_ready[i]),
            .cnt_clr    (cnt_clr),
            .out_valid  (out_valid[i]),
            .out_data   (out_data[i]),
            .beat_cnt   (beat_cnt[i]),
            .slot_ready (slot_ready[i])
        );
    end

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Random and directed stimulus against a queue-per-channel reference model of the demux.
module tb_demux_stream_1x4;

    localparam int W    = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_data;
    logic [1:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [3:0][W-1:0]  out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             cnt_clr;
    logic [3:0][CW-1:0] beat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mq [4][$];
    int           mcnt [4];

    demux_stream_1x4 #(.WIDTH(W), .SEL_BITS(2), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check outputs against the model mid-cycle, advance the model, then cross the edge.
    task automatic step();
        bit acc;
        int s;
        @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("vld%0d", ch), 32'(out_valid[ch]), 32'(mq[ch].size() != 0));
            if (mq[ch].size() != 0)
                chk($sformatf("dat%0d", ch), 32'(out_data[ch]), 32'(mq[ch][0]));
            chk($sformatf("cnt%0d", ch), 32'(beat_cnt[ch]), 32'(mcnt[ch]));
        end
        if (in_valid) begin
            s = int'(in_sel);
            chk("in_ready", 32'(in_ready), 32'(mq[s].size() == 0 || out_ready[s]));
        end
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                mq[ch].delete();
                mcnt[ch] = 0;
            end
        end else begin
            acc = 1'b0;
            if (in_valid) begin
                s   = int'(in_sel);
                acc = (mq[s].size() == 0) || out_ready[s];
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (mq[ch].size() != 0 && out_ready[ch]) begin
                    void'(mq[ch].pop_front());
                    if (mcnt[ch] < CMAX) mcnt[ch]++;
                end
                if (cnt_clr) mcnt[ch] = 0;
            end
            if (acc) mq[int'(in_sel)].push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = 2'(sel);
        in_data  = d;
        step();
    endtask

    initial begin
        for (int ch = 0; ch < 4; ch++) mcnt[ch] = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 8'hFF;
        out_ready = 4'h0;
        cnt_clr   = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_dat", 32'(out_data), 32'h0);
        chk("rst_cnt", 32'(beat_cnt), 32'h0);

        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        // Round robin with all channels ready
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) send(i, 8'((i + 1) * 8'h11));
        in_valid = 1'b0;
        step();
        for (int ch = 0; ch < 4; ch++) chk($sformatf("rr_cnt%0d", ch), 32'(beat_cnt[ch]), 32'd1);

        // Stall isolation on channel 2
        out_ready = 4'b1011;
        send(2, 8'hA5);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h5A;
        #1;
        chk("stall_rdy", 32'(in_ready), 32'd0);
        step();
        send(0, 8'h3C);
        in_valid = 1'b0;
        chk("stall_v0", 32'(out_valid[0]), 32'd1);
        chk("stall_d0", 32'(out_data[0]), 32'h3C);
        chk("stall_v2", 32'(out_valid[2]), 32'd1);
        chk("stall_d2", 32'(out_data[2]), 32'hA5);
        step();
        out_ready = 4'hF;
        step();
        step();

        // Back-to-back on channel 1
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) send(1, 8'(8'h80 + i));
        in_valid = 1'b0;
        step();
        chk("b2b_cnt1", 32'(beat_cnt[1]), 32'd8);

        // Saturation on channel 3, then clear colliding with a handshake
        for (int i = 0; i < 300; i++) send(3, 8'($urandom));
        chk("sat_cnt3", 32'(beat_cnt[3]), 32'd255);
        cnt_clr = 1'b1;
        send(3, 8'h77);
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt3", 32'(beat_cnt[3]), 32'd0);
        step();
        chk("post_clr_cnt3", 32'(beat_cnt[3]), 32'd1);

        // Reset while channel 0 is stalled
        out_ready = 4'b1110;
        send(0, 8'hC3);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 4'hF;
        chk("rstall_v0", 32'(out_valid[0]), 32'd0);
        step();
        step();
        chk("rstall_cnt0", 32'(beat_cnt[0]), 32'd0);

        // Unknown select while idle must not disturb state
        in_valid = 1'b0;
        in_sel   = 2'bxx;
        for (int i = 0; i < 3; i++) step();
        in_sel = 2'd0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            for (int ch = 0; ch < 4; ch++) out_ready[ch] = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst      = 1'b0;
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
